scs8hd_scan_unload: RTL and testbench

//  - Readback/unload end of the flop-capture path: takes a parallel word captured by a bank of
//    D flops and serializes it MSB-first onto a 1-bit valid/ready stream.
//  - Sits between a capture register bank and the scan/debug readout; pure synchronous logic.

---
 rtl/scs8hd_scan_pkg.sv | 10 +
 rtl/scs8hd_scan_bitcnt.sv | 18 +
 rtl/scs8hd_scan_unload.sv | 70 +++++++
 tb/tb_scs8hd_scan_unload.sv | 125 ++++++++++++
 4 files changed

// File: rtl/scs8hd_scan_pkg.sv
// scs8hd_scan_pkg: shared FSM state encoding and output reset values for the scan unload block
package scs8hd_scan_pkg;
  localparam int STATE_W = 2;
  typedef enum logic [STATE_W-1:0] {IDLE, SHIFT, PARITY} state_e;
  localparam logic SO_RST        = 1'b0;
  localparam logic SO_VALID_RST  = 1'b0;
  localparam logic SO_LAST_RST   = 1'b0;
  localparam logic BUSY_RST      = 1'b0;
  localparam logic CAP_READY_RST = 1'b1;
endpackage

// File: rtl/scs8hd_scan_bitcnt.sv
// scs8hd_scan_bitcnt: bit counter with clear/increment and terminal count at WIDTH-1
// Ports: CLK, RESET_B (sync active-low), clr_i (priority clear), inc_i (increment),
//        tc_o (count == WIDTH-1)
module scs8hd_scan_bitcnt #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic CLK,
  input  logic RESET_B,
  input  logic clr_i,
  input  logic inc_i,
  output logic tc_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : inc_i ? cnt_q + CNT_W'(1) : cnt_q;
  always_ff @(posedge CLK) cnt_q <= !RESET_B ? '0 : cnt_d;
  assign tc_o = cnt_q == CNT_W'(WIDTH-1);
endmodule

// File: rtl/scs8hd_scan_unload.sv
// scs8hd_scan_unload: serializes a captured parallel word MSB-first onto a valid/ready bit stream
// Ports: CLK, RESET_B (sync active-low); CAP_VALID/CAP_READY/CAP_DATA capture handshake;
//        SO/SO_VALID/SO_READY/SO_LAST serial stream; BUSY frame in progress.
// Option: SCS8HD_SCAN_PARITY_EN appends an even-parity bit to every frame.
module scs8hd_scan_unload
  import scs8hd_scan_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic             CLK,
  input  logic             RESET_B,
  input  logic             CAP_VALID,
  output logic             CAP_READY,
  input  logic [WIDTH-1:0] CAP_DATA,
  output logic             SO,
  output logic             SO_VALID,
  input  logic             SO_READY,
  output logic             SO_LAST,
  output logic             BUSY
);
  state_e state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic tc, hs;
  assign hs = SO_VALID & SO_READY;
  // Clear on the final data handshake so the count stays within 0..WIDTH-1.
  scs8hd_scan_bitcnt #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_bitcnt (
    .CLK    (CLK),
    .RESET_B(RESET_B),
    .clr_i  (state_q == IDLE || (hs && tc)),
    .inc_i  (state_q == SHIFT && hs),
    .tc_o   (tc)
  );
`ifdef SCS8HD_SCAN_PARITY_EN
  logic par_q;
  always_ff @(posedge CLK)
    par_q <= !RESET_B ? 1'b0 : (state_q == IDLE && CAP_VALID) ? ^CAP_DATA : par_q;
  assign SO      = state_q == PARITY ? par_q : sreg_q[WIDTH-1];
  assign SO_LAST = state_q == PARITY;
`else
  assign SO      = sreg_q[WIDTH-1];
  assign SO_LAST = state_q == SHIFT && tc;
`endif
  assign SO_VALID  = state_q != IDLE;
  assign BUSY      = state_q != IDLE;
  assign CAP_READY = state_q == IDLE;
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    case (state_q)
      IDLE: if (CAP_VALID) begin
        sreg_d  = CAP_DATA;
        state_d = SHIFT;
      end
      SHIFT: if (SO_READY) begin
        sreg_d = sreg_q << 1;
`ifdef SCS8HD_SCAN_PARITY_EN
        if (tc) state_d = PARITY;
`else
        if (tc) state_d = IDLE;
`endif
      end
      default: if (SO_READY) state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    state_q <= !RESET_B ? IDLE : state_d;
    sreg_q  <= !RESET_B ? '0 : sreg_d;
  end
endmodule

// File: tb/tb_scs8hd_scan_unload.sv
// tb_scs8hd_scan_unload: self-checking bench for the scan unload serializer
module tb_scs8hd_scan_unload;
`ifdef SCS8HD_SCAN_PARITY_EN
  localparam bit PE = 1'b1;
`else
  localparam bit PE = 1'b0;
`endif
  localparam int FL = 16 + (PE ? 1 : 0);
  logic CLK = 1'b0, RESET_B = 1'b0, CAP_VALID = 1'b0, SO_READY = 1'b0;
  logic [15:0] CAP_DATA = '0;
  logic CAP_READY, SO, SO_VALID, SO_LAST, BUSY;
  int n = 0, errs = 0;
  typedef struct {logic [15:0] d; int mode; bit inj;} vec_t;
  vec_t vecs[6];

  scs8hd_scan_unload #(.WIDTH(16)) dut (
    .CLK(CLK), .RESET_B(RESET_B), .CAP_VALID(CAP_VALID), .CAP_READY(CAP_READY),
    .CAP_DATA(CAP_DATA), .SO(SO), .SO_VALID(SO_VALID), .SO_READY(SO_READY),
    .SO_LAST(SO_LAST), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, a, e, $time);
    end
  endtask

  // Frame = data bits MSB first, then even parity of the word when enabled.
  function automatic logic exp_bit(input logic [15:0] d, input int i);
    return i < 16 ? d[15-i] : ^d;
  endfunction

  task automatic run_frame(input logic [15:0] d, input int mode, input bit inj);
    int idx = 0, cyc = 0;
    bit r;
    @(negedge CLK);
    chk("cap_ready_idle", CAP_READY, 1);
    CAP_VALID = 1'b1; CAP_DATA = d; SO_READY = 1'b0;
    @(negedge CLK);
    CAP_VALID = 1'b0; CAP_DATA = '0;
    while (idx < FL && cyc < 1000) begin
      chk("so_valid", SO_VALID, 1);
      chk("busy", BUSY, 1);
      chk("cap_ready_busy", CAP_READY, 0);
      chk("so_bit", SO, exp_bit(d, idx));
      chk("so_last", SO_LAST, idx == FL-1);
      r = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
      SO_READY = r;
      if (inj) begin CAP_VALID = 1'($urandom_range(0, 1)); CAP_DATA = 16'h1234; end
      @(negedge CLK);
      if (r) idx++;
      cyc++;
    end
    chk("frame_handshakes", idx, FL);
    SO_READY = 1'b0; CAP_VALID = 1'b0; CAP_DATA = '0;
    chk("end_so_valid", SO_VALID, 0);
    chk("end_cap_ready", CAP_READY, 1);
    chk("end_busy", BUSY, 0);
  endtask

  initial begin
    vecs[0] = '{16'hA5C3, 0, 1'b0};
    vecs[1] = '{16'hA5C3, 1, 1'b0};
    vecs[2] = '{16'hA5C3, 0, 1'b1};
    vecs[3] = '{16'h0001, 0, 1'b0};
    vecs[4] = '{16'hFFFF, 1, 1'b0};
    vecs[5] = '{16'h8000, 2, 1'b1};
    repeat (2) @(negedge CLK);
    chk("rst_so", SO, 0);
    chk("rst_so_valid", SO_VALID, 0);
    chk("rst_so_last", SO_LAST, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_cap_ready", CAP_READY, 1);
    RESET_B = 1'b1;
    for (int i = 0; i < 6; i++) run_frame(vecs[i].d, vecs[i].mode, vecs[i].inj);
    // Reset after the 5th bit of an all-ones frame aborts it.
    @(negedge CLK);
    CAP_VALID = 1'b1; CAP_DATA = 16'hFFFF; SO_READY = 1'b1;
    @(negedge CLK);
    CAP_VALID = 1'b0;
    repeat (5) @(negedge CLK);
    chk("pre_rst_busy", BUSY, 1);
    RESET_B = 1'b0;
    @(negedge CLK);
    chk("abort_so_valid", SO_VALID, 0);
    chk("abort_busy", BUSY, 0);
    chk("abort_cap_ready", CAP_READY, 1);
    chk("abort_so", SO, 0);
    chk("abort_so_last", SO_LAST, 0);
    RESET_B = 1'b1; SO_READY = 1'b0;
    run_frame(16'h0001, 0, 1'b0);
    // Back-to-back captures with CAP_VALID held high: one idle cycle between frames.
    @(negedge CLK);
    CAP_VALID = 1'b1; CAP_DATA = 16'hFFFF; SO_READY = 1'b1;
    for (int i = 1; i <= 2*FL+1; i++) begin
      @(negedge CLK);
      CAP_DATA = 16'h0000;
      if (i == FL+1) begin
        chk("b2b_gap_valid", SO_VALID, 0);
        chk("b2b_gap_ready", CAP_READY, 1);
      end else begin
        chk("b2b_valid", SO_VALID, 1);
        chk("b2b_bit", SO, i <= FL ? exp_bit(16'hFFFF, i-1) : exp_bit(16'h0000, i-FL-2));
        chk("b2b_last", SO_LAST, i == FL || i == 2*FL+1);
      end
    end
    CAP_VALID = 1'b0;
    @(negedge CLK);
    chk("b2b_end_busy", BUSY, 0);
    SO_READY = 1'b0;
    for (int i = 0; i < 20; i++) run_frame(16'($urandom), 2, 1'($urandom_range(0, 1)));
    $display("== %0d vectors applied, %0d miscompares ==", n, errs);
    $finish;
  end
endmodule
